// File: rtl/position_updater_pkg.sv
// rtl/position_updater_pkg.sv - shared constants and FSM encoding for the position updater
package position_updater_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int AXIS_W = 11;
    localparam int X_RST  = 400;
    localparam int Y_RST  = 300;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/position_updater_if.sv
// rtl/position_updater_if.sv - buttons, position feedback and write port of the position memory
interface position_updater_if;
    import position_updater_pkg::*;

    logic           btn_up;
    logic           btn_down;
    logic           btn_left;
    logic           btn_right;
    logic [X_W-1:0] Xcur;
    logic [Y_W-1:0] Ycur;
    logic [X_W-1:0] Xnew;
    logic [Y_W-1:0] Ynew;
    logic           WE;
    logic           busy;

    modport master (
        input  btn_up, btn_down, btn_left, btn_right, Xcur, Ycur,
        output Xnew, Ynew, WE, busy
    );

    modport slave (
        output btn_up, btn_down, btn_left, btn_right, Xcur, Ycur,
        input  Xnew, Ynew, WE, busy
    );

endinterface

// File: rtl/position_updater_move_tick_gen.sv
// rtl/position_updater_move_tick_gen.sv - free-running divider producing a one-cycle movement tick
module move_tick_gen #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick on the last count, then wrap back to zero.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/position_updater.sv
// rtl/position_updater.sv - per-tick clamped object move with a single write strobe to position memory
module position_updater
    import position_updater_pkg::*;
#(
    parameter int STEP     = 8,
    parameter int H_RES    = position_updater_pkg::H_RES,
    parameter int V_RES    = position_updater_pkg::V_RES,
    parameter int OBJ_W    = 32,
    parameter int OBJ_H    = 32,
    parameter int TICK_DIV = 2_500_000,
    parameter int X_RST    = position_updater_pkg::X_RST,
    parameter int Y_RST    = position_updater_pkg::Y_RST
) (
    input  logic               clk,
    input  logic               reset,
    position_updater_if.master bus
);

    localparam logic [AXIS_W-1:0] XMAX   = AXIS_W'(H_RES - OBJ_W);
    localparam logic [AXIS_W-1:0] YMAX   = AXIS_W'(V_RES - OBJ_H);
    localparam logic [AXIS_W-1:0] STEP_A = AXIS_W'(STEP);

    // Opposing buttons cancel; the result is always pulled into [0, lim],
    // which also repairs feedback that is already out of range.
    function automatic logic [AXIS_W-1:0] axis_next(
        input logic [AXIS_W-1:0] cur,
        input logic              dec,
        input logic              inc,
        input logic [AXIS_W-1:0] step,
        input logic [AXIS_W-1:0] lim
    );
        logic [AXIS_W-1:0] raw;
        if (dec && !inc) begin
            raw = (cur < step) ? '0 : cur - step;
        end else if (inc && !dec) begin
            raw = cur + step;
        end else begin
            raw = cur;
        end
        return (raw > lim) ? lim : raw;
    endfunction

    logic              tick;
    state_t            state_q, state_d;
    logic [3:0]        btn_q, btn_d;
    logic [X_W-1:0]    xnew_q, xnew_d;
    logic [Y_W-1:0]    ynew_q, ynew_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic [AXIS_W-1:0] x_cur, y_cur, x_tgt, y_tgt;

    move_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Target position from the latched buttons {up, down, left, right} and memory feedback.
    always_comb begin
        x_cur = {1'b0, bus.Xcur};
        y_cur = {2'b00, bus.Ycur};
        x_tgt = axis_next(x_cur, btn_q[1], btn_q[0], STEP_A, XMAX);
        y_tgt = axis_next(y_cur, btn_q[3], btn_q[2], STEP_A, YMAX);
    end

    // Next state; WE and busy are derived from the next state so they leave the flops clean.
    always_comb begin
        state_d = state_q;
        btn_d   = btn_q;
        xnew_d  = xnew_q;
        ynew_d  = ynew_q;
        case (state_q)
            IDLE: begin
                if (tick && (bus.btn_up || bus.btn_down || bus.btn_left || bus.btn_right)) begin
                    btn_d   = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
                    state_d = CALC;
                end
            end
            CALC: begin
                if ((x_tgt != x_cur) || (y_tgt != y_cur)) begin
                    xnew_d  = x_tgt[X_W-1:0];
                    ynew_d  = y_tgt[Y_W-1:0];
                    state_d = STROBE;
                end else begin
                    state_d = IDLE;
                end
            end
            STROBE:  state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        we_d   = (state_d == STROBE);
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            btn_q   <= '0;
            xnew_q  <= X_W'(X_RST);
            ynew_q  <= Y_W'(Y_RST);
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            xnew_q  <= xnew_d;
            ynew_q  <= ynew_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Xnew = xnew_q;
    assign bus.Ynew = ynew_q;
    assign bus.WE   = we_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_position_updater.sv
// tb/tb_position_updater.sv - randomized model-checked bench for position_updater with a memory model
module tb_position_updater;

    localparam int STEP = 8;
    localparam int XMAX = 608;
    localparam int YMAX = 448;
    localparam int TDIV = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn   = 4'b0000;   // {up, down, left, right}
    logic [9:0] mem_x = 10'd400;
    logic [8:0] mem_y = 9'd300;
    logic       we_prev = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycle index since reset and the scheduled effects of the last tick.
    int k       = 0;
    int busy_lo = -1;
    int busy_hi = -1;
    int we_cyc  = -1;
    int upd_cyc = -1;
    int exp_x   = 400;
    int exp_y   = 300;
    int pend_x  = 0;
    int pend_y  = 0;
    int we_count   = 0;
    int busy_count = 0;

    always #5 clk = ~clk;

    position_updater_if bus ();

    assign bus.btn_up    = btn[3];
    assign bus.btn_down  = btn[2];
    assign bus.btn_left  = btn[1];
    assign bus.btn_right = btn[0];
    assign bus.Xcur      = mem_x;
    assign bus.Ycur      = mem_y;

    position_updater #(
        .STEP    (8),
        .H_RES   (640),
        .V_RES   (480),
        .OBJ_W   (32),
        .OBJ_H   (32),
        .TICK_DIV(TDIV),
        .X_RST   (400),
        .Y_RST   (300)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // One clock: memory write on WE rise, compare against the model, then apply new inputs.
    task automatic step(input logic [3:0] b, input logic r);
        int nx;
        int ny;
        @(negedge clk);
        if (bus.WE && !we_prev) begin
            mem_x = bus.Xnew;
            mem_y = bus.Ynew;
        end
        we_prev = bus.WE;
        if (bus.WE)   we_count++;
        if (bus.busy) busy_count++;
        if (k == upd_cyc) begin
            exp_x = pend_x;
            exp_y = pend_y;
        end
        check("WE",   int'(bus.WE),   int'(k == we_cyc));
        check("busy", int'(bus.busy), int'(k >= busy_lo && k <= busy_hi));
        check("Xnew", int'(bus.Xnew), exp_x);
        check("Ynew", int'(bus.Ynew), exp_y);
        btn   = b;
        reset = r;
        if (r) begin
            k = 0;
            mem_x = 10'd400;
            mem_y = 9'd300;
            we_prev = 1'b0;
            exp_x = 400;
            exp_y = 300;
            busy_lo = -1;
            busy_hi = -1;
            we_cyc  = -1;
            upd_cyc = -1;
        end else begin
            if ((k % TDIV) == TDIV - 1 && b != 4'b0000) begin
                nx = clamp(int'(mem_x) + (b[0] ? STEP : 0) - (b[1] ? STEP : 0), XMAX);
                ny = clamp(int'(mem_y) + (b[2] ? STEP : 0) - (b[3] ? STEP : 0), YMAX);
                busy_lo = k + 1;
                if (nx != int'(mem_x) || ny != int'(mem_y)) begin
                    busy_hi = k + 3;
                    we_cyc  = k + 2;
                    upd_cyc = k + 2;
                    pend_x  = nx;
                    pend_y  = ny;
                end else begin
                    busy_hi = k + 1;
                end
            end
            k++;
        end
    endtask

    task automatic run(input logic [3:0] b, input int n);
        repeat (n) step(b, 1'b0);
    endtask

    initial begin
        int w0;
        int b0;

        repeat (3) step(4'b0000, 1'b1);
        run(4'b0000, 1);
        run(4'b0000, 3);

        // Right held for three ticks from 400/300.
        w0 = we_count;
        run(4'b0001, 12);
        run(4'b0000, 4);
        check("right_x",  int'(bus.Xnew), 424);
        check("right_y",  int'(bus.Ynew), 300);
        check("right_we", we_count - w0, 3);

        // Left from X=5 clamps to 0, then stays without a write.
        mem_x = 10'd5;
        w0 = we_count;
        run(4'b0010, 4);
        run(4'b0000, 4);
        check("left_x",  int'(bus.Xnew), 0);
        check("left_we", we_count - w0, 1);
        w0 = we_count;
        run(4'b0010, 4);
        run(4'b0000, 4);
        check("left_edge_x",  int'(bus.Xnew), 0);
        check("left_edge_we", we_count - w0, 0);

        // Down from Y=444 clamps to 448, then stays.
        mem_y = 9'd444;
        w0 = we_count;
        run(4'b0100, 4);
        run(4'b0000, 4);
        check("down_y",  int'(bus.Ynew), 448);
        check("down_we", we_count - w0, 1);
        w0 = we_count;
        run(4'b0100, 4);
        run(4'b0000, 4);
        check("down_edge_we", we_count - w0, 0);

        // Up+down cancel, right moves, from 400/448.
        mem_x = 10'd400;
        w0 = we_count;
        run(4'b1101, 4);
        run(4'b0000, 4);
        check("diag_x",  int'(bus.Xnew), 408);
        check("diag_y",  int'(bus.Ynew), 448);
        check("diag_we", we_count - w0, 1);

        // Reset asserted during the STROBE cycle.
        run(4'b0001, 4);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        check("rst_we",   int'(bus.WE),   0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_x",    int'(bus.Xnew), 400);
        check("rst_y",    int'(bus.Ynew), 300);
        run(4'b0000, 3);
        run(4'b0001, 4);
        run(4'b0000, 4);
        check("resume_x", int'(bus.Xnew), 408);

        // Ten idle ticks.
        w0 = we_count;
        b0 = busy_count;
        run(4'b0000, 40);
        check("idle_we",   we_count - w0, 0);
        check("idle_busy", busy_count - b0, 0);
        check("idle_x",    int'(bus.Xnew), 408);

        // Random buttons changing every cycle, with occasional out-of-range feedback.
        repeat (60) begin
            if ($urandom_range(0, 3) == 0) begin
                run(4'b0000, 4);
                mem_x = 10'($urandom_range(0, 700));
                mem_y = 9'($urandom_range(0, 500));
            end
            repeat (4) step(4'($urandom_range(0, 15)), 1'b0);
        end
        run(4'b0000, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
